// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, branch, jump, multiply/divide
// and external-freeze conditions into per-register flush/load/hold controls
// and a PC enable. It also keeps a saturating count of bubble cycles.
//
// state   | meaning
// --------+----------------------------------------------------------------
// RUN     | normal issue; hazards are resolved by priority each cycle
// MD_BUSY | multiply/divide in flight; front end held until md_cnt reaches 0
module pipe_hazard_ctrl #(
   parameter int MD_LAT = 4,
   parameter int SCNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        ID_Rs,
   input  logic [4:0]        ID_Rt,
   input  logic              ID_UsesRs,
   input  logic              ID_UsesRt,
   input  logic              ID_Jump,
   input  logic              EX_MemRead,
   input  logic [4:0]        EX_WriteReg,
   input  logic              EX_BranchTaken,
   input  logic              EX_MDStart,
   input  logic              Freeze,
   output logic [1:0]        IFID_cond,
   output logic [1:0]        IDEX_cond,
   output logic [1:0]        EXMEM_cond,
   output logic              PC_write,
   output logic              MD_done,
   output logic [1:0]        state,
   output logic [SCNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_BUSY = 2'd1
   } state_t;

   localparam logic [1:0] C_FLUSH = 2'd0;
   localparam logic [1:0] C_LOAD  = 2'd1;
   localparam logic [1:0] C_HOLD  = 2'd2;
   localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

   state_t          state_q;
   state_t          state_d;
   logic [3:0]      md_cnt;
   logic [3:0]      md_cnt_d;
   logic [1:0]      stall_inc;
   logic [SCNT_W:0] stall_sum;
   logic            load_use;

   // A load whose destination is a live source of the ID instruction;
   // r0 is hard-wired so it never creates a dependency.
   assign load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                     ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                      (ID_UsesRt && (ID_Rt == EX_WriteReg)));

   assign state     = state_q;
   assign stall_sum = {1'b0, stall_count} + {{(SCNT_W-1){1'b0}}, stall_inc};

   // State, multiply/divide countdown and saturating stall statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         md_cnt      <= 4'd0;
         stall_count <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt      <= md_cnt_d;
         stall_count <= stall_sum[SCNT_W] ? '1 : stall_sum[SCNT_W-1:0];
      end
   end

   // Next state and zero-latency pipeline controls; reset forces all low.
   always_comb begin
      state_d    = state_q;
      md_cnt_d   = md_cnt;
      stall_inc  = 2'd0;
      IFID_cond  = C_LOAD;
      IDEX_cond  = C_LOAD;
      EXMEM_cond = C_LOAD;
      PC_write   = 1'b1;
      MD_done    = 1'b0;

      case (state_q)
         RUN: begin
            if (Freeze) begin
               IFID_cond  = C_HOLD;
               IDEX_cond  = C_HOLD;
               EXMEM_cond = C_HOLD;
               PC_write   = 1'b0;
            end else if (EX_BranchTaken) begin
               // Two wrong-path instructions are squashed, hence the +2.
               IFID_cond  = C_FLUSH;
               IDEX_cond  = C_FLUSH;
               stall_inc  = 2'd2;
            end else if (EX_MDStart) begin
               IFID_cond  = C_HOLD;
               IDEX_cond  = C_HOLD;
               EXMEM_cond = C_FLUSH;
               PC_write   = 1'b0;
               stall_inc  = 2'd1;
               state_d    = MD_BUSY;
               md_cnt_d   = MD_INIT;
            end else if (load_use) begin
               IFID_cond  = C_HOLD;
               IDEX_cond  = C_FLUSH;
               PC_write   = 1'b0;
               stall_inc  = 2'd1;
            end else if (ID_Jump) begin
               IFID_cond  = C_FLUSH;
            end
         end
         MD_BUSY: begin
            if (Freeze) begin
               IFID_cond  = C_HOLD;
               IDEX_cond  = C_HOLD;
               EXMEM_cond = C_HOLD;
               PC_write   = 1'b0;
            end else if (md_cnt != 4'd0) begin
               IFID_cond  = C_HOLD;
               IDEX_cond  = C_HOLD;
               EXMEM_cond = C_FLUSH;
               PC_write   = 1'b0;
               stall_inc  = 2'd1;
               md_cnt_d   = md_cnt - 4'd1;
            end else begin
               MD_done    = 1'b1;
               state_d    = RUN;
            end
         end
         default: begin
            // Unreachable encodings: hold the pipe for one edge and recover.
            IFID_cond  = C_HOLD;
            IDEX_cond  = C_HOLD;
            EXMEM_cond = C_HOLD;
            PC_write   = 1'b0;
            state_d    = RUN;
            md_cnt_d   = 4'd0;
         end
      endcase

      if (!reset) begin
         IFID_cond  = C_FLUSH;
         IDEX_cond  = C_FLUSH;
         EXMEM_cond = C_FLUSH;
         PC_write   = 1'b0;
         MD_done    = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Two instances share stimulus: the
// default one and one with a 2-bit stall counter to observe saturation.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_WriteReg = '0;
   logic       ID_UsesRs = 0, ID_UsesRt = 0, ID_Jump = 0, EX_MemRead = 0;
   logic       EX_BranchTaken = 0, EX_MDStart = 0, Freeze = 0;

   logic [1:0]  a_ifid, a_idex, a_exmem, a_st;
   logic        a_pc, a_done;
   logic [15:0] a_sc;
   logic [1:0]  b_ifid, b_idex, b_exmem, b_st;
   logic        b_pc, b_done;
   logic [1:0]  b_sc;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MD_LAT(4), .SCNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
      .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
      .EX_BranchTaken(EX_BranchTaken), .EX_MDStart(EX_MDStart), .Freeze(Freeze),
      .IFID_cond(a_ifid), .IDEX_cond(a_idex), .EXMEM_cond(a_exmem),
      .PC_write(a_pc), .MD_done(a_done), .state(a_st), .stall_count(a_sc)
   );

   pipe_hazard_ctrl #(.MD_LAT(4), .SCNT_W(2)) dut_sat (
      .clk(clk), .reset(reset),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
      .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
      .EX_BranchTaken(EX_BranchTaken), .EX_MDStart(EX_MDStart), .Freeze(Freeze),
      .IFID_cond(b_ifid), .IDEX_cond(b_idex), .EXMEM_cond(b_exmem),
      .PC_write(b_pc), .MD_done(b_done), .state(b_st), .stall_count(b_sc)
   );

   typedef struct {
      string      tag;
      logic [1:0] ifid, idex, exmem, st;
      logic       pc, done;
      int         sc, sc2;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_sc = 0;
   int   exp_sc2 = 0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle on negedge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.tag, ".ifid"},  int'(a_ifid),  int'(e.ifid));
         chk({e.tag, ".idex"},  int'(a_idex),  int'(e.idex));
         chk({e.tag, ".exmem"}, int'(a_exmem), int'(e.exmem));
         chk({e.tag, ".pc"},    int'(a_pc),    int'(e.pc));
         chk({e.tag, ".done"},  int'(a_done),  int'(e.done));
         chk({e.tag, ".state"}, int'(a_st),    int'(e.st));
         chk({e.tag, ".sc"},    int'(a_sc),    e.sc);
         chk({e.tag, ".s.ifid"},  int'(b_ifid),  int'(e.ifid));
         chk({e.tag, ".s.idex"},  int'(b_idex),  int'(e.idex));
         chk({e.tag, ".s.exmem"}, int'(b_exmem), int'(e.exmem));
         chk({e.tag, ".s.pc"},    int'(b_pc),    int'(e.pc));
         chk({e.tag, ".s.done"},  int'(b_done),  int'(e.done));
         chk({e.tag, ".s.state"}, int'(b_st),    int'(e.st));
         chk({e.tag, ".s.sc"},    int'(b_sc),    e.sc2);
      end
   end

   task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic mr, input logic [4:0] wr,
                        input logic j, input logic br, input logic mds, input logic frz);
      ID_Rs = rs; ID_UsesRs = urs; ID_Rt = rt; ID_UsesRt = urt;
      EX_MemRead = mr; EX_WriteReg = wr; ID_Jump = j;
      EX_BranchTaken = br; EX_MDStart = mds; Freeze = frz;
   endtask

   // Push the expected view of the current cycle, then advance the tallies.
   task automatic expect_now(input string tag, input logic [1:0] f, input logic [1:0] d,
                             input logic [1:0] x, input logic pc, input logic dn,
                             input logic [1:0] st, input int inc);
      exp_t e;
      e.tag = tag; e.ifid = f; e.idex = d; e.exmem = x; e.pc = pc; e.done = dn;
      e.st = st; e.sc = exp_sc; e.sc2 = exp_sc2;
      sb.push_back(e);
      exp_sc  = (exp_sc + inc > 65535) ? 65535 : exp_sc + inc;
      exp_sc2 = (exp_sc2 + inc > 3) ? 3 : exp_sc2 + inc;
   endtask

   task automatic step(input string tag,
                       input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] wr,
                       input logic j, input logic br, input logic mds, input logic frz,
                       input logic [1:0] f, input logic [1:0] d, input logic [1:0] x,
                       input logic pc, input logic dn, input logic [1:0] st, input int inc);
      @(posedge clk);
      #1;
      drive(rs, urs, rt, urt, mr, wr, j, br, mds, frz);
      expect_now(tag, f, d, x, pc, dn, st, inc);
   endtask

   task automatic idle(input string tag);
      step(tag, 0,0,0,0,0,0, 0,0,0,0, 1,1,1,1,0,0, 0);
   endtask

   initial begin
      // Held in reset: everything reads zero.
      step("rst",     0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0);
      @(negedge clk); #1 reset = 1'b1;

      idle("normal");
      //     tag         rs urs rt urt mr wr j br md fz  ifid idex exm pc dn st inc
      step("lu_rs",      8, 1, 0, 0, 1, 8, 0,0,0,0,  2,0,1,0,0,0, 1);
      idle("after_lu");
      step("lu_rt",      3, 1, 9, 1, 1, 9, 0,0,0,0,  2,0,1,0,0,0, 1);
      step("lu_unused",  8, 0, 0, 0, 1, 8, 0,0,0,0,  1,1,1,1,0,0, 0);
      step("lu_r0",      0, 1, 0, 1, 1, 0, 0,0,0,0,  1,1,1,1,0,0, 0);
      step("lu_nomr",    8, 1, 0, 0, 0, 8, 0,0,0,0,  1,1,1,1,0,0, 0);
      step("jump",       0, 0, 0, 0, 0, 0, 1,0,0,0,  0,1,1,1,0,0, 0);
      step("lu_ov_jmp",  8, 1, 0, 0, 1, 8, 1,0,0,0,  2,0,1,0,0,0, 1);
      step("br_all",     8, 1, 0, 0, 1, 8, 1,1,0,0,  0,0,1,1,0,0, 2);
      step("frz_run",    8, 1, 0, 0, 1, 8, 1,1,1,1,  2,2,2,0,0,0, 0);
      // Multiply/divide with 3-cycle freeze at md_cnt=2.
      step("md_start",   0, 0, 0, 0, 0, 0, 0,0,1,0,  2,2,0,0,0,0, 1);
      step("md_c3_br",   8, 1, 0, 0, 1, 8, 1,1,1,0,  2,2,0,0,0,1, 1);
      for (int i = 0; i < 3; i++)
         step("md_frz",  0, 0, 0, 0, 0, 0, 0,0,0,1,  2,2,2,0,0,1, 0);
      step("md_c2",      0, 0, 0, 0, 0, 0, 0,0,0,0,  2,2,0,0,0,1, 1);
      step("md_c1",      0, 0, 0, 0, 0, 0, 0,0,0,0,  2,2,0,0,0,1, 1);
      step("md_done",    0, 0, 0, 0, 0, 0, 0,0,0,0,  1,1,1,1,1,1, 0);
      idle("md_after");
      // Async reset in the middle of a multiply/divide.
      step("md2_start",  0, 0, 0, 0, 0, 0, 0,0,1,0,  2,2,0,0,0,0, 1);
      step("md2_c3",     0, 0, 0, 0, 0, 0, 0,0,0,0,  2,2,0,0,0,1, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(0,0,0,0,0,0, 0,0,0,0);
      #1;
      exp_sc = 0; exp_sc2 = 0;
      expect_now("async_rst", 0,0,0,0,0,0, 0);
      @(negedge clk); #1 reset = 1'b1;
      idle("post_rst");
      // Five back-to-back load-use stalls saturate the 2-bit counter.
      for (int i = 0; i < 5; i++)
         step("lu_sat",  5, 1, 0, 0, 1, 5, 0,0,0,0,  2,0,1,0,0,0, 1);
      idle("sat_end");
      @(negedge clk); #1;
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, 4, multiply/divide latency in cycles, legal 1..15.
REQ-002 SHALL have parameter SCNT_W, 16, width of stall statistics counter.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have ports ID_Rs, ID_Rt  in  5 each  source registers of instruction in ID.
REQ-006 SHALL have ports ID_UsesRs, ID_UsesRt  in  1 each  ID instruction reads Rs / Rt.
REQ-007 SHALL have port ID_Jump  in  1  jump (j/jal/jr) decoded in ID.
REQ-008 SHALL have ports EX_MemRead  in  1 and EX_WriteReg  in  5  load in EX and its destination.
REQ-009 SHALL have port EX_BranchTaken  in  1  branch resolved taken in EX.
REQ-010 SHALL have port EX_MDStart  in  1  multiply/divide instruction present in EX.
REQ-011 SHALL have port Freeze  in  1  external whole-pipeline stall (memory wait).
REQ-012 SHALL have ports IFID_cond, IDEX_cond, EXMEM_cond  out  2 each  pipeline-register control: 0 flush, 1 load, 2 hold; 3 never driven.
REQ-013 SHALL have port PC_write  out  1  PC register update enable.
REQ-014 SHALL have ports MD_done  out  1 (one-cycle pulse), state  out  2, stall_count  out  SCNT_W.

Function
REQ-015 SHALL implement states RUN=0 and MD_BUSY=1 with a 4-bit down counter md_cnt; encodings 2,3 unreachable and SHALL recover to RUN on next edge.
REQ-016 SHALL compute all cond/PC_write outputs combinationally from state, md_cnt and inputs (zero latency; consumed by registers at the same edge).
REQ-017 Load-use hazard SHALL be EX_MemRead & EX_WriteReg!=0 & ((ID_UsesRs & ID_Rs==EX_WriteReg) | (ID_UsesRt & ID_Rt==EX_WriteReg)).
REQ-018 RUN priority, highest first: Freeze > EX_BranchTaken > EX_MDStart > load-use > ID_Jump > normal.
REQ-019 Freeze: all cond=2, PC_write=0; state, md_cnt, stall_count unchanged (also in MD_BUSY).
REQ-020 Branch taken: IFID=0, IDEX=0, EXMEM=1, PC_write=1; stays RUN; stall_count += 2.
REQ-021 MDStart in RUN: IFID=2, IDEX=2, EXMEM=0, PC_write=0; next state MD_BUSY, md_cnt<=MD_LAT-1.
REQ-022 MD_BUSY with md_cnt!=0: same stall pattern as REQ-021; md_cnt decrements; EX_BranchTaken/EX_MDStart/load-use/ID_Jump ignored.
REQ-023 MD_BUSY with md_cnt==0: all cond=1, PC_write=1, MD_done=1; next state RUN. Total stall = MD_LAT cycles.
REQ-024 Load-use: IFID=2, IDEX=0, EXMEM=1, PC_write=0; one bubble per occurrence; stays RUN.
REQ-025 Jump: IFID=0, IDEX=1, EXMEM=1, PC_write=1.
REQ-026 Normal: all cond=1, PC_write=1, MD_done=0.
REQ-027 stall_count SHALL add 1 per cycle with IDEX=0 or EXMEM=0 (excluding branch, per REQ-020) and saturate at all-ones.
REQ-028 Load-use with EX_WriteReg==0 SHALL NOT stall.

Reset
REQ-029 While reset==0: state=RUN, md_cnt=0, stall_count=0, MD_done=0, all cond=0, PC_write=0, regardless of clk.
REQ-030 Reset asserted mid-MD_BUSY SHALL abort immediately; first edge after release operates in RUN.

Verification
REQ-031 ld r8 in EX, ID reads Rs=8 -> one cycle IFID=2, IDEX=0, PC_write=0; next cycle all 1; stall_count=1.
REQ-032 MD_LAT=4, EX_MDStart pulse -> 4 cycles IFID=IDEX=2, EXMEM=0; 5th cycle all 1, MD_done=1; stall_count=4.
REQ-033 EX_BranchTaken with simultaneous load-use and ID_Jump -> IFID=0, IDEX=0, EXMEM=1, PC_write=1; stall_count=2.
REQ-034 Freeze held 3 cycles at md_cnt=2 in MD_BUSY -> all cond=2; md_cnt stays 2; completion delayed exactly 3 cycles.
REQ-035 reset=0 asynchronously mid-MD_BUSY -> outputs all 0 without clock edge; state=0, stall_count=0.
REQ-036 SCNT_W=2, five consecutive load-use stalls -> stall_count saturates at 3.
